hilo_muldiv: RTL and testbench

Parametrised iterative multiply/divide unit owning the HI/LO register pair for the pipelined MIPS core. It sits beside the execute-stage ALU and accepts MULT/MULTU/DIV/DIVU/MTHI/MTLO from the controller. It holds the pipeline via `busy_o` while iterating, and commits results to HI/LO atomically on completion. It generalises the fixed two-bit HI/LO write enable to a WIDTH-parametrised, multi-cycle, flushable engine.

---
 rtl/hilo_muldiv.sv | 161 ++++++++++++++++
 tb/tb_hilo_muldiv.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/hilo_muldiv.sv
// Iterative multiply/divide unit owning the HI/LO pair; mul/div take WIDTH+1 cycles, MTHI/MTLO commit at once.
// Optional divider datapath is compiled in with `define HILO_DIV_EN; otherwise DIV/DIVU report divide-by-zero.
module hilo_muldiv #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_i,
   input  logic [2:0]       op_i,
   input  logic [WIDTH-1:0] a_i,
   input  logic [WIDTH-1:0] b_i,
   input  logic             flush_i,
   output logic             busy_o,
   output logic             done_o,
   output logic             divzero_o,
   output logic [WIDTH-1:0] hi_o,
   output logic [WIDTH-1:0] lo_o
);
   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {IDLE, RUN, FIX, ZDONE} state_t;

   state_t             state, state_nxt;
   logic [CW-1:0]      cnt;
   logic [WIDTH-1:0]   opnd;
   logic [2*WIDTH-1:0] prod;
   logic               neg_lo;
   logic [2*WIDTH-1:0] prod_step;
   logic [WIDTH-1:0]   fix_hi, fix_lo;

   logic               accept, signed_op, a_neg, b_neg, div_op;
   logic [WIDTH-1:0]   a_mag, b_mag;

   assign accept    = (state == IDLE) && start_i && !flush_i;
   assign signed_op = ~op_i[0];
   assign div_op    = (op_i[2:1] == 2'b01);
   assign a_neg     = signed_op & a_i[WIDTH-1];
   assign b_neg     = signed_op & b_i[WIDTH-1];
   assign a_mag     = a_neg ? -a_i : a_i;
   assign b_mag     = b_neg ? -b_i : b_i;
   assign busy_o    = (state != IDLE);

   // Multiply: prod holds {partial sum, remaining multiplier bits}; one add-and-shift per cycle.
   logic [WIDTH:0] mul_sum;
   logic [2*WIDTH-1:0] mul_step, mul_fix;
   assign mul_sum  = {1'b0, prod[2*WIDTH-1:WIDTH]} + {1'b0, (prod[0] ? opnd : '0)};
   assign mul_step = {mul_sum, prod[WIDTH-1:1]};
   assign mul_fix  = neg_lo ? -prod : prod;

`ifdef HILO_DIV_EN
   logic               is_div, neg_hi;
   logic [WIDTH:0]     rem_sh, rem_diff;
   logic [2*WIDTH-1:0] div_step;
   logic [WIDTH-1:0]   quot, rem;
   // Divide: prod holds {partial remainder, dividend bits shifting out / quotient bits shifting in}.
   assign rem_sh   = prod[2*WIDTH-1:WIDTH-1];
   assign rem_diff = rem_sh - {1'b0, opnd};
   assign div_step = rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0], prod[WIDTH-2:0], 1'b0}
                                     : {rem_diff[WIDTH-1:0], prod[WIDTH-2:0], 1'b1};
   assign quot      = prod[WIDTH-1:0];
   assign rem       = prod[2*WIDTH-1:WIDTH];
   assign prod_step = is_div ? div_step : mul_step;
   assign fix_hi    = is_div ? (neg_hi ? -rem : rem) : mul_fix[2*WIDTH-1:WIDTH];
   assign fix_lo    = is_div ? (neg_lo ? -quot : quot) : mul_fix[WIDTH-1:0];
`else
   assign prod_step = mul_step;
   assign fix_hi    = mul_fix[2*WIDTH-1:WIDTH];
   assign fix_lo    = mul_fix[WIDTH-1:0];
`endif

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE: begin
            if (accept && !op_i[2]) begin
`ifdef HILO_DIV_EN
               if (div_op && (b_i == '0)) state_nxt = ZDONE;
               else                       state_nxt = RUN;
`else
               state_nxt = div_op ? ZDONE : RUN;
`endif
            end
         end
         RUN:     if (cnt == CW'(WIDTH - 1)) state_nxt = FIX;
         FIX:     state_nxt = IDLE;
         ZDONE:   state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
      if (flush_i) state_nxt = IDLE;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         opnd      <= '0;
         prod      <= '0;
         neg_lo    <= 1'b0;
         hi_o      <= '0;
         lo_o      <= '0;
         done_o    <= 1'b0;
         divzero_o <= 1'b0;
`ifdef HILO_DIV_EN
         is_div    <= 1'b0;
         neg_hi    <= 1'b0;
`endif
      end else begin
         state     <= state_nxt;
         done_o    <= 1'b0;
         divzero_o <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  case (op_i)
                     3'b100: hi_o <= a_i;
                     3'b101: lo_o <= a_i;
                     3'b000, 3'b001: begin
                        opnd   <= a_mag;
                        prod   <= {{WIDTH{1'b0}}, b_mag};
                        neg_lo <= a_neg ^ b_neg;
                        cnt    <= '0;
`ifdef HILO_DIV_EN
                        is_div <= 1'b0;
`endif
                     end
`ifdef HILO_DIV_EN
                     3'b010, 3'b011: begin
                        opnd   <= b_mag;
                        prod   <= {{WIDTH{1'b0}}, a_mag};
                        neg_lo <= a_neg ^ b_neg;
                        neg_hi <= a_neg;
                        cnt    <= '0;
                        is_div <= 1'b1;
                     end
`endif
                     default: ;
                  endcase
               end
            end
            RUN: begin
               prod <= prod_step;
               cnt  <= cnt + CW'(1);
            end
            FIX: begin
               if (!flush_i) begin
                  hi_o   <= fix_hi;
                  lo_o   <= fix_lo;
                  done_o <= 1'b1;
               end
            end
            ZDONE: begin
               if (!flush_i) begin
                  done_o    <= 1'b1;
                  divzero_o <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed self-checking bench for hilo_muldiv at WIDTH=32; divide checks follow the HILO_DIV_EN build option.
module tb_hilo_muldiv;
   logic        clk, rst, start, flush;
   logic [2:0]  op;
   logic [31:0] a, b;
   logic        busy, done, divzero;
   logic [31:0] hi, lo;

   int checks = 0;
   int errors = 0;
   int bc, dc, zc;

   hilo_muldiv #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
      .flush_i(flush), .busy_o(busy), .done_o(done), .divzero_o(divzero),
      .hi_o(hi), .lo_o(lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Drive a start before E0 and return #1 after E0.
   task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      start = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   // Issue an op, count busy cycles and done/divzero pulses until busy drops (bounded).
   task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      issue(o, x, y);
      bc = 0; dc = 0; zc = 0;
      for (int i = 0; i < 60 && busy; i++) begin
         bc++;
         @(posedge clk); #1;
         if (done) dc++;
         if (divzero) zc++;
      end
      check("busy_dropped", {31'd0, busy}, 32'd0);
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; flush = 1'b0; op = 3'b000; a = '0; b = '0;
      repeat (2) @(posedge clk);
      #1;
      check("rst_busy", {31'd0, busy}, 32'd0);
      check("rst_done", {31'd0, done}, 32'd0);
      check("rst_divzero", {31'd0, divzero}, 32'd0);
      check("rst_hi", hi, 32'h0);
      check("rst_lo", lo, 32'h0);
      @(negedge clk); rst = 1'b0;

      // MULT -1 * 2
      run_op(3'b000, 32'hFFFFFFFF, 32'h00000002);
      check("mult_busy_cycles", 32'(bc), 32'd33);
      check("mult_done_cnt", 32'(dc), 32'd1);
      check("mult_divzero_cnt", 32'(zc), 32'd0);
      check("mult_hi", hi, 32'hFFFFFFFF);
      check("mult_lo", lo, 32'hFFFFFFFE);
      @(posedge clk); #1;
      check("mult_done_one_cycle", {31'd0, done}, 32'd0);

      // MULTU 0xFFFFFFFF * 2
      run_op(3'b001, 32'hFFFFFFFF, 32'h00000002);
      check("multu_busy_cycles", 32'(bc), 32'd33);
      check("multu_done_cnt", 32'(dc), 32'd1);
      check("multu_hi", hi, 32'h00000001);
      check("multu_lo", lo, 32'hFFFFFFFE);

`ifdef HILO_DIV_EN
      run_op(3'b010, 32'hFFFFFFF9, 32'h00000002);
      check("div_neg_busy_cycles", 32'(bc), 32'd33);
      check("div_neg_done_cnt", 32'(dc), 32'd1);
      check("div_neg_lo", lo, 32'hFFFFFFFD);
      check("div_neg_hi", hi, 32'hFFFFFFFF);

      run_op(3'b011, 32'd100, 32'd7);
      check("divu_lo", lo, 32'h0000000E);
      check("divu_hi", hi, 32'h00000002);

      run_op(3'b010, 32'h80000000, 32'hFFFFFFFF);
      check("div_wrap_lo", lo, 32'h80000000);
      check("div_wrap_hi", hi, 32'h00000000);

      run_op(3'b011, 32'd55, 32'd0);
      check("divz_busy_cycles", 32'(bc), 32'd1);
      check("divz_done_cnt", 32'(dc), 32'd1);
      check("divz_divzero_cnt", 32'(zc), 32'd1);
      check("divz_hi_kept", hi, 32'h00000000);
      check("divz_lo_kept", lo, 32'h80000000);
`else
      run_op(3'b011, 32'd100, 32'd7);
      check("nodiv_busy_cycles", 32'(bc), 32'd1);
      check("nodiv_done_cnt", 32'(dc), 32'd1);
      check("nodiv_divzero_cnt", 32'(zc), 32'd1);
      check("nodiv_hi_kept", hi, 32'h00000001);
      check("nodiv_lo_kept", lo, 32'hFFFFFFFE);
`endif
      @(posedge clk); #1;
      check("divzero_one_cycle", {31'd0, divzero}, 32'd0);

      // MTHI / MTLO: visible right after the accepting edge, no stall
      issue(3'b100, 32'h12345678, 32'h0);
      check("mthi_hi", hi, 32'h12345678);
      check("mthi_busy", {31'd0, busy}, 32'd0);
      issue(3'b101, 32'h9ABCDEF0, 32'h0);
      check("mtlo_lo", lo, 32'h9ABCDEF0);
      check("mtlo_hi_kept", hi, 32'h12345678);
      check("mtlo_busy", {31'd0, busy}, 32'd0);

      // Undefined opcode is ignored
      issue(3'b110, 32'hDEADBEEF, 32'h1);
      check("undef_busy", {31'd0, busy}, 32'd0);
      check("undef_hi_kept", hi, 32'h12345678);

      // MULTU flushed mid-run
      issue(3'b001, 32'd5, 32'd7);
      repeat (9) begin @(posedge clk); #1; end
      check("flush_pre_busy", {31'd0, busy}, 32'd1);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      check("flush_busy", {31'd0, busy}, 32'd0);
      dc = 0;
      for (int i = 0; i < 40; i++) begin
         if (done) dc++;
         @(posedge clk); #1;
      end
      check("flush_no_done", 32'(dc), 32'd0);
      check("flush_hi_kept", hi, 32'h12345678);
      check("flush_lo_kept", lo, 32'h9ABCDEF0);

      // Asynchronous reset mid-MULT
      issue(3'b000, 32'h00001234, 32'h00000010);
      repeat (4) begin @(posedge clk); #1; end
      #2 rst = 1'b1;
      #1;
      check("arst_busy", {31'd0, busy}, 32'd0);
      check("arst_hi", hi, 32'h0);
      check("arst_lo", lo, 32'h0);
      @(negedge clk); rst = 1'b0;

      run_op(3'b001, 32'd3, 32'd5);
      check("post_rst_done_cnt", 32'(dc), 32'd1);
      check("post_rst_lo", lo, 32'd15);
      check("post_rst_hi", hi, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
